// File: rtl/atm_pkg.sv
// atm_pkg: session FSM state encoding and reject reason codes, shared with the transaction FSM
package atm_pkg;
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LOOKUP   = 3'd1;
   localparam logic [2:0] ST_WAIT_PIN = 3'd2;
   localparam logic [2:0] ST_CHECK    = 3'd3;
   localparam logic [2:0] ST_AUTH     = 3'd4;
   localparam logic [2:0] ST_REJECT   = 3'd5;
   typedef enum logic [2:0] {
      ERR_NONE    = 3'd0,
      ERR_NO_ACC  = 3'd1,
      ERR_LOCKED  = 3'd2,
      ERR_TIMEOUT = 3'd3
   } err_e;
endpackage

// File: rtl/atm_session_ctrl_timer.sv
// session_timer: saturating idle counter; expired flags that TIMEOUT_CYC-1 has been reached
module session_timer #(
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT_CYC);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);
   logic [W-1:0] cnt_q, cnt_d;
   assign expired = cnt_q == LAST;
   always_comb cnt_d = clr ? '0 : (en && !expired) ? cnt_q + W'(1) : cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: per-card session sequencer (account lookup, PIN check with lockout, idle timeout)
module atm_session_ctrl
   import atm_pkg::*;
#(
   parameter int NUM_ACC      = 10,
   parameter int MAX_ATTEMPTS = 3,
   parameter int TIMEOUT_CYC  = 1000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               card_in,
   input  logic [3:0]         acc_num,
   input  logic [15:0]        pin,
   input  logic               pin_valid,
   input  logic               activity,
   input  logic               logout,
   input  logic               unlock,
   input  logic [3:0]         unlock_idx,
   input  logic               auth_found,
   input  logic [3:0]         auth_index,
   input  logic [15:0]        exp_pin,
   output logic [3:0]         auth_acc_num,
   output logic [3:0]         pin_rd_idx,
   output logic               session_active,
   output logic [3:0]         acc_idx,
   output logic               pin_wrong,
   output logic [2:0]         attempts_left,
   output logic               eject,
   output logic [2:0]         err_code,
   output logic [NUM_ACC-1:0] lock_map
);
   localparam logic [2:0] ATT_MAX = 3'(MAX_ATTEMPTS);
   logic [2:0] state_q, state_d, attempts_q, attempts_d;
   logic [3:0] auth_acc_q, auth_acc_d, pin_rd_idx_q, pin_rd_idx_d, acc_idx_q, acc_idx_d;
   logic [15:0] pin_q, pin_d;
   logic pin_wrong_q, pin_wrong_d, session_q, session_d, eject_q, eject_d;
   err_e err_q, err_d;
   logic [NUM_ACC-1:0] lock_q, lock_d;
   logic lock_set, acc_locked, tmr_clr, tmr_en, tmr_exp;
   session_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk(clk), .rst_n(rst_n), .clr(tmr_clr), .en(tmr_en), .expired(tmr_exp)
   );
   // Set is applied after clear so a lockout in the same cycle as an admin unlock sticks
   always_comb begin
      acc_locked = 1'b0;
      lock_d = lock_q;
      for (int i = 0; i < NUM_ACC; i++) begin
         acc_locked = acc_locked | (lock_q[i] & (auth_index == 4'(i)));
         if (unlock && unlock_idx == 4'(i)) lock_d[i] = 1'b0;
         if (lock_set && pin_rd_idx_q == 4'(i)) lock_d[i] = 1'b1;
      end
   end
   always_comb begin
      state_d = state_q;
      auth_acc_d = auth_acc_q;
      pin_rd_idx_d = pin_rd_idx_q;
      pin_d = pin_q;
      acc_idx_d = acc_idx_q;
      attempts_d = attempts_q;
      err_d = err_q;
      pin_wrong_d = 1'b0;
      lock_set = 1'b0;
      tmr_clr = 1'b0;
      tmr_en = 1'b0;
      if (state_q != ST_IDLE && !card_in) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (card_in) begin
               auth_acc_d = acc_num;
               err_d = ERR_NONE;
               state_d = ST_LOOKUP;
            end
            ST_LOOKUP: if (!auth_found) begin
               err_d = ERR_NO_ACC;
               state_d = ST_REJECT;
            end else if (acc_locked) begin
               err_d = ERR_LOCKED;
               state_d = ST_REJECT;
            end else begin
               pin_rd_idx_d = auth_index;
               attempts_d = ATT_MAX;
               tmr_clr = 1'b1;
               state_d = ST_WAIT_PIN;
            end
            ST_WAIT_PIN: begin
               tmr_en = 1'b1;
               if (pin_valid) begin
                  pin_d = pin;
                  state_d = ST_CHECK;
               end else if (tmr_exp) begin
                  err_d = ERR_TIMEOUT;
                  state_d = ST_REJECT;
               end
            end
            ST_CHECK: if (pin_q == exp_pin) begin
               acc_idx_d = pin_rd_idx_q;
               tmr_clr = 1'b1;
               state_d = ST_AUTH;
            end else begin
               attempts_d = attempts_q - 3'd1;
               pin_wrong_d = 1'b1;
               lock_set = attempts_q == 3'd1;
               err_d = lock_set ? ERR_LOCKED : err_q;
               tmr_clr = !lock_set;
               state_d = lock_set ? ST_REJECT : ST_WAIT_PIN;
            end
            ST_AUTH: begin
               tmr_en = 1'b1;
               if (logout) begin
                  state_d = ST_IDLE;
               end else if (activity) begin
                  tmr_clr = 1'b1;
               end else if (tmr_exp) begin
                  err_d = ERR_TIMEOUT;
                  state_d = ST_REJECT;
               end
            end
            ST_REJECT: state_d = ST_REJECT;
            default: state_d = ST_IDLE;
         endcase
      end
      session_d = state_d == ST_AUTH;
      eject_d = state_d == ST_REJECT;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         auth_acc_q <= '0;
         pin_rd_idx_q <= '0;
         pin_q <= '0;
         acc_idx_q <= '0;
         attempts_q <= ATT_MAX;
         err_q <= ERR_NONE;
         pin_wrong_q <= 1'b0;
         session_q <= 1'b0;
         eject_q <= 1'b0;
         lock_q <= '0;
      end else begin
         state_q <= state_d;
         auth_acc_q <= auth_acc_d;
         pin_rd_idx_q <= pin_rd_idx_d;
         pin_q <= pin_d;
         acc_idx_q <= acc_idx_d;
         attempts_q <= attempts_d;
         err_q <= err_d;
         pin_wrong_q <= pin_wrong_d;
         session_q <= session_d;
         eject_q <= eject_d;
         lock_q <= lock_d;
      end
   end
   assign auth_acc_num = auth_acc_q;
   assign pin_rd_idx = pin_rd_idx_q;
   assign session_active = session_q;
   assign acc_idx = acc_idx_q;
   assign pin_wrong = pin_wrong_q;
   assign attempts_left = attempts_q;
   assign eject = eject_q;
   assign err_code = err_q;
   assign lock_map = lock_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: directed and randomized card sessions checked against a session-level model
module tb_atm_session_ctrl;
   import atm_pkg::*;
   localparam int NUM_ACC = 10;
   localparam int MAX_ATT = 3;
   localparam int TMO = 1000;
   logic clk = 1'b0, rst_n = 1'b0, card_in = 1'b0, pin_valid = 1'b0;
   logic activity = 1'b0, logout = 1'b0, unlock = 1'b0, auth_found;
   logic [3:0] acc_num = '0, unlock_idx = '0, auth_index, auth_acc_num, pin_rd_idx, acc_idx;
   logic [15:0] pin = '0, exp_pin;
   logic session_active, pin_wrong, eject;
   logic [2:0] attempts_left, err_code;
   logic [NUM_ACC-1:0] lock_map;
   int total = 0, bad = 0;
   logic [NUM_ACC-1:0] m_lock = '0;
   logic [2:0] m_err = ERR_NONE;
   int m_att = MAX_ATT, m_idx = 0;
   always #5 clk = ~clk;
   atm_session_ctrl #(.NUM_ACC(NUM_ACC), .MAX_ATTEMPTS(MAX_ATT), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .card_in(card_in), .acc_num(acc_num), .pin(pin),
      .pin_valid(pin_valid), .activity(activity), .logout(logout), .unlock(unlock),
      .unlock_idx(unlock_idx), .auth_found(auth_found), .auth_index(auth_index),
      .exp_pin(exp_pin), .auth_acc_num(auth_acc_num), .pin_rd_idx(pin_rd_idx),
      .session_active(session_active), .acc_idx(acc_idx), .pin_wrong(pin_wrong),
      .attempts_left(attempts_left), .eject(eject), .err_code(err_code), .lock_map(lock_map)
   );
   // Account database: account numbers 1..NUM_ACC live at index acc-1
   function automatic logic [15:0] pin_of(input int i);
      return 16'(1234 + 1111 * i);
   endfunction
   always_comb begin
      auth_found = auth_acc_num >= 4'd1 && int'(auth_acc_num) <= NUM_ACC;
      auth_index = auth_acc_num - 4'd1;
      exp_pin = pin_of(int'(pin_rd_idx));
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic check_outs(input string tag, input logic sa, input logic ej, input logic pw);
      check({tag, ".active"}, 32'(session_active), 32'(sa));
      check({tag, ".eject"}, 32'(eject), 32'(ej));
      check({tag, ".pin_wrong"}, 32'(pin_wrong), 32'(pw));
      check({tag, ".err"}, 32'(err_code), 32'(m_err));
      check({tag, ".attempts"}, 32'(attempts_left), 32'(m_att));
      check({tag, ".lock"}, 32'(lock_map), 32'(m_lock));
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic insert(input int acc, output bit ok);
      bit found;
      card_in = 1'b1;
      acc_num = 4'(acc);
      tick();
      acc_num = 4'($urandom);
      m_err = ERR_NONE;
      check("lookup.acc", 32'(auth_acc_num), 32'(acc));
      check_outs("lookup", 1'b0, 1'b0, 1'b0);
      tick();
      found = acc >= 1 && acc <= NUM_ACC;
      ok = found && !m_lock[acc-1];
      if (!found) m_err = ERR_NO_ACC;
      else if (!ok) m_err = ERR_LOCKED;
      else begin
         m_idx = acc - 1;
         m_att = MAX_ATT;
      end
      check_outs("insert", 1'b0, !ok, 1'b0);
      if (ok) check("insert.idx", 32'(pin_rd_idx), 32'(m_idx));
   endtask
   // res: 0 = back to PIN entry, 1 = authenticated, 2 = locked out
   task automatic enter_pin(input logic [15:0] p, input int gap, input bit ul, output int res);
      repeat (gap) tick();
      if (gap > 0) check_outs("wait", 1'b0, 1'b0, 1'b0);
      pin = p;
      pin_valid = 1'b1;
      tick();
      pin_valid = 1'b0;
      pin = 16'($urandom);
      check_outs("check", 1'b0, 1'b0, 1'b0);
      unlock = ul;
      unlock_idx = 4'(m_idx);
      tick();
      unlock = 1'b0;
      if (p == pin_of(m_idx)) begin
         res = 1;
         check_outs("auth", 1'b1, 1'b0, 1'b0);
         check("auth.idx", 32'(acc_idx), 32'(m_idx));
      end else begin
         m_att--;
         if (m_att == 0) begin
            res = 2;
            m_lock[m_idx] = 1'b1;
            m_err = ERR_LOCKED;
            check_outs("locked", 1'b0, 1'b1, 1'b1);
         end else begin
            res = 0;
            check_outs("retry", 1'b0, 1'b0, 1'b1);
         end
      end
   endtask
   task automatic remove();
      card_in = 1'b0;
      tick();
      check_outs("removed", 1'b0, 1'b0, 1'b0);
   endtask
   task automatic end_session();
      logout = 1'b1;
      tick();
      logout = 1'b0;
      check_outs("logout", 1'b0, 1'b0, 1'b0);
      remove();
   endtask
   task automatic do_unlock(input int idx);
      unlock = 1'b1;
      unlock_idx = 4'(idx);
      tick();
      unlock = 1'b0;
      if (idx < NUM_ACC) m_lock[idx] = 1'b0;
   endtask
   task automatic reset_model();
      m_lock = '0;
      m_err = ERR_NONE;
      m_att = MAX_ATT;
   endtask
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end
   initial begin
      bit ok;
      int res;
      #12;
      check_outs("reset", 1'b0, 1'b0, 1'b0);
      check("reset.auth_acc", 32'(auth_acc_num), 32'd0);
      check("reset.acc_idx", 32'(acc_idx), 32'd0);
      #10 rst_n = 1'b1;
      tick();
      insert(3, ok);
      enter_pin(16'd3456, 2, 1'b0, res);
      check("t1.acc_idx", 32'(acc_idx), 32'd2);
      end_session();
      insert(3, ok);
      enter_pin(16'd1111, 1, 1'b0, res);
      enter_pin(16'd2222, 1, 1'b0, res);
      enter_pin(16'd3333, 1, 1'b0, res);
      tick();
      check_outs("t2.held", 1'b0, 1'b1, 1'b0);
      remove();
      insert(3, ok);
      check("t2.relock", 32'(ok), 32'd0);
      do_unlock(2);
      check_outs("t2.unlock_in_reject", 1'b0, 1'b1, 1'b0);
      remove();
      foreach (m_lock[i]) m_lock[i] = 1'b0;
      insert(12, ok);
      tick();
      check_outs("t3.held", 1'b0, 1'b1, 1'b0);
      remove();
      insert(0, ok);
      remove();
      insert(11, ok);
      remove();
      insert(1, ok);
      repeat (TMO - 1) tick();
      check_outs("t4.before_expiry", 1'b0, 1'b0, 1'b0);
      tick();
      m_err = ERR_TIMEOUT;
      check_outs("t4.expired", 1'b0, 1'b1, 1'b0);
      remove();
      insert(1, ok);
      enter_pin(pin_of(0), TMO - 1, 1'b0, res);
      for (int k = 1; k <= 3000; k++) begin
         activity = k % 500 == 0;
         tick();
         activity = 1'b0;
         if (k % 100 == 0) check_outs("t5.keepalive", 1'b1, 1'b0, 1'b0);
      end
      repeat (TMO - 1) tick();
      check_outs("t5.before_expiry", 1'b1, 1'b0, 1'b0);
      tick();
      m_err = ERR_TIMEOUT;
      check_outs("t5.expired", 1'b0, 1'b1, 1'b0);
      remove();
      insert(4, ok);
      enter_pin(pin_of(0), 0, 1'b0, res);
      repeat (3) tick();
      remove();
      insert(5, ok);
      enter_pin(16'd0, 0, 1'b0, res);
      enter_pin(16'd0, 0, 1'b0, res);
      pin = 16'd0;
      pin_valid = 1'b1;
      tick();
      pin_valid = 1'b0;
      remove();
      insert(8, ok);
      enter_pin(16'd0, 0, 1'b0, res);
      enter_pin(16'd0, 0, 1'b0, res);
      enter_pin(16'd0, 0, 1'b1, res);
      remove();
      insert(6, ok);
      pin = 16'd0;
      pin_valid = 1'b1;
      tick();
      pin_valid = 1'b0;
      #2 rst_n = 1'b0;
      card_in = 1'b0;
      #1;
      reset_model();
      check_outs("t6.async_reset", 1'b0, 1'b0, 1'b0);
      check("t6.rd_idx", 32'(pin_rd_idx), 32'd0);
      #3 rst_n = 1'b1;
      tick();
      check_outs("t6.after_reset", 1'b0, 1'b0, 1'b0);
      repeat (60) begin
         if ($urandom_range(0, 2) == 0) begin
            do_unlock(int'($urandom_range(0, 15)));
            check("rnd.unlock", 32'(lock_map), 32'(m_lock));
         end
         insert(int'($urandom_range(0, 11)), ok);
         if (!ok) begin
            repeat ($urandom_range(0, 3)) tick();
            check_outs("rnd.reject", 1'b0, 1'b1, 1'b0);
            remove();
            continue;
         end
         res = 0;
         while (res == 0) begin
            if ($urandom_range(0, 9) == 0) break;
            enter_pin($urandom_range(0, 4) < 2 ? pin_of(m_idx) : pin_of(m_idx) ^ 16'(1 + $urandom_range(0, 7)),
                      int'($urandom_range(0, 4)), 1'b0, res);
         end
         if (res == 1) begin
            repeat ($urandom_range(0, 10)) begin
               activity = $urandom_range(0, 1) == 1;
               tick();
               activity = 1'b0;
            end
            check_outs("rnd.session", 1'b1, 1'b0, 1'b0);
            if ($urandom_range(0, 1) == 1) end_session();
            else remove();
         end else remove();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
